// File: rtl/toggle_cover_pkg.sv
// Shared helpers for the toggle-coverage detector: bit counting and counter sizing.
package toggle_cover_pkg;

  // Widest vector popcount accepts; narrower vectors are zero-extended by the caller.
  localparam int POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return cnt;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// Per-bit toggle cell: sticky rise/fall flags and a one-shot pulse on first full toggle.
module toggle_cover_bit (
  input  logic gbl_clk,
  input  logic reset,
  input  logic prev,
  input  logic sig,
  input  logic sample,
  input  logic clr,
  output logic rise_seen,
  output logic fall_seen,
  output logic valid,
  output logic newcov
);

  logic rise_nxt;
  logic fall_nxt;

  // With sample low the flags hold, so newcov can only fire on a detecting cycle.
  always_comb begin
    rise_nxt = rise_seen | (sample & sig & ~prev);
    fall_nxt = fall_seen | (sample & ~sig & prev);
    newcov   = ~(rise_seen & fall_seen) & rise_nxt & fall_nxt;
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      rise_seen <= 1'b0;
      fall_seen <= 1'b0;
      valid     <= 1'b0;
    end else if (clr) begin
      rise_seen <= 1'b0;
      fall_seen <= 1'b0;
      valid     <= 1'b0;
    end else begin
      rise_seen <= rise_nxt;
      fall_seen <= fall_nxt;
      valid     <= newcov;
    end
  end

endmodule

// File: rtl/toggle_cover_detect.sv
// Toggle-coverage front end: samples sig, tracks per-bit transitions and pulses valid once per
// bit per coverage epoch for the downstream reporter.
module toggle_cover_detect
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             gbl_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] rise_seen,
  output logic [WIDTH-1:0] fall_seen,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  logic [WIDTH-1:0] prev;
  logic             armed;
  logic             sample;
  logic [WIDTH-1:0] newcov;

  // Detection needs a valid previous sample, so the first enabled cycle only captures.
  assign sample = en & ~clear & armed;

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      prev  <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      armed <= 1'b0;
    end else if (en) begin
      prev  <= sig;
      armed <= 1'b1;
    end else begin
      armed <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_cover_bit u_bit (
      .gbl_clk  (gbl_clk),
      .reset    (reset),
      .prev     (prev[i]),
      .sig      (sig[i]),
      .sample   (sample),
      .clr      (clear),
      .rise_seen(rise_seen[i]),
      .fall_seen(fall_seen[i]),
      .valid    (valid[i]),
      .newcov   (newcov[i])
    );
  end

  // Each bit completes at most once per epoch, so the count never exceeds WIDTH.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      covered_cnt <= '0;
    end else if (clear) begin
      covered_cnt <= '0;
    end else begin
      covered_cnt <= covered_cnt + CNT_W'(popcount(POP_MAX_W'(newcov)));
    end
  end

  assign all_covered = (covered_cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Table-driven scoreboard bench for toggle_cover_detect (WIDTH = 15).
module tb_toggle_cover_detect;

  localparam int WIDTH = 15;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             gbl_clk;
  logic             reset;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] rise_seen;
  logic [WIDTH-1:0] fall_seen;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  toggle_cover_detect #(.WIDTH(WIDTH)) dut (
    .gbl_clk    (gbl_clk),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .sig        (sig),
    .valid      (valid),
    .rise_seen  (rise_seen),
    .fall_seen  (fall_seen),
    .covered_cnt(covered_cnt),
    .all_covered(all_covered)
  );

  initial gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] exp_valid;
    logic [WIDTH-1:0] exp_rise;
    logic [WIDTH-1:0] exp_fall;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step       = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic c, input logic [WIDTH-1:0] s,
                              input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] ri,
                              input logic [WIDTH-1:0] fa, input int cnt);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.sig = s;
    t.exp_valid = v; t.exp_rise = ri; t.exp_fall = fa; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    reset = t.rst;
    en    = t.en;
    clear = t.clr;
    sig   = t.sig;
    sb.push_back(t);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue expected entry", step);
      return;
    end
    e = sb.pop_front();
    compare("valid",       32'(valid),       32'(e.exp_valid));
    compare("rise_seen",   32'(rise_seen),   32'(e.exp_rise));
    compare("fall_seen",   32'(fall_seen),   32'(e.exp_fall));
    compare("covered_cnt", 32'(covered_cnt), 32'(e.exp_cnt));
    compare("all_covered", 32'(all_covered), 32'(e.exp_cnt == WIDTH));
  endtask

  task automatic runVec(input vec_t t);
    applyStimulus(t);
    @(posedge gbl_clk);
    #1;
    checkOutput();
    step++;
  endtask

  initial begin
    int               k;
    logic [WIDTH-1:0] m;
    int               hit;
    int               waited;

    reset = 1'b0; en = 1'b0; clear = 1'b0; sig = '0;

    // reset held three cycles
    vecs.push_back(mk(0, 0, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    // capture-only first enabled cycle, even with sig moving
    vecs.push_back(mk(1, 1, 0, 15'h0010, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0010, 0));
    // bit 3 rise then fall
    vecs.push_back(mk(1, 1, 0, 15'h0008, 15'h0000, 15'h0008, 15'h0010, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0008, 15'h0008, 15'h0018, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0008, 15'h0018, 1));
    // bit 3 toggles again: no new pulse
    vecs.push_back(mk(1, 1, 0, 15'h0008, 15'h0000, 15'h0008, 15'h0018, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0008, 15'h0018, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0008, 15'h0000, 15'h0008, 15'h0018, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0008, 15'h0018, 1));
    // clear, capture, then all bits toggle together
    vecs.push_back(mk(1, 1, 1, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h7FFF, 15'h0000, 15'h7FFF, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, 15));
    // clear, then bit 5 rises during a disabled window
    vecs.push_back(mk(1, 1, 1, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 15'h0020, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0020, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0020, 0));
    // cover bits 0..6 (bit 5 completes first), several bits in one cycle
    vecs.push_back(mk(1, 1, 0, 15'h007F, 15'h0020, 15'h007F, 15'h0020, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h005F, 15'h007F, 15'h007F, 7));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h007F, 15'h007F, 7));
    // clear while sig[0] toggles; bit 0 later pulses again
    vecs.push_back(mk(1, 1, 1, 15'h0001, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0001, 15'h0000, 15'h0001, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0001, 15'h0001, 15'h0001, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0001, 15'h0001, 1));
    // reset mid-operation drops the pulse in flight
    vecs.push_back(mk(1, 1, 0, 15'h0002, 15'h0000, 15'h0003, 15'h0001, 1));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0002, 15'h0003, 15'h0003, 2));
    vecs.push_back(mk(0, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i]);
    end

    // random bit full toggle: bounded wait for its pulse, then confirm it lasts one cycle
    k = $urandom_range(WIDTH - 1, 0);
    m = '0;
    m[k] = 1'b1;
    runVec(mk(1, 1, 0, m, 15'h0000, m, 15'h0000, 0));
    reset = 1'b1; en = 1'b1; clear = 1'b0; sig = '0;
    hit = 0;
    waited = 0;
    while (!hit && waited < 4) begin
      @(posedge gbl_clk);
      #1;
      waited++;
      if (valid != '0) hit = 1;
    end
    compare("pulse_seen", 32'(hit), 32'd1);
    compare("pulse_latency", 32'(waited), 32'd1);
    compare("pulse_value", 32'(valid), 32'(m));
    compare("pulse_cnt", 32'(covered_cnt), 32'd1);
    @(posedge gbl_clk);
    #1;
    compare("pulse_width", 32'(valid), 32'd0);
    compare("pulse_cnt_hold", 32'(covered_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
